// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - shared types, encodings and sizes for the data-memory responder
package data_mem_resp_pkg;

  localparam int cXLEN     = 32;
  localparam int cRamDepth = 1024;
  localparam int cAddrW    = $clog2(cRamDepth);

  // RISC-V funct3 load/store size encodings
  localparam logic [2:0] cLsB  = 3'b000;
  localparam logic [2:0] cLsH  = 3'b001;
  localparam logic [2:0] cLsW  = 3'b010;
  localparam logic [2:0] cLsBU = 3'b100;
  localparam logic [2:0] cLsHU = 3'b101;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [2:0]       opType;
    logic [4:0]       rdAddr;
  } tMemOp;

  typedef struct packed {
    logic             dv;
    logic [4:0]       addr;
    logic [cXLEN-1:0] data;
  } tRegOp;

  typedef enum logic [1:0] {IDLE, BEAT1, RESP} tLsState;

  // Byte-lane mask of an access at offset 0, from the low two funct3 bits
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_byte_ram.sv
// rtl/data_mem_resp_byte_ram.sv - single-port word RAM with byte write enables and registered read
module data_mem_resp_byte_ram
  import data_mem_resp_pkg::*;
(
  input  logic              iClk,
  input  logic [cAddrW-1:0] iAddr,
  input  logic [3:0]        iWe,
  input  logic [cXLEN-1:0]  iWdata,
  output logic [cXLEN-1:0]  oRdata
);

  logic [cXLEN-1:0] mem_q [cRamDepth];
  logic [cXLEN-1:0] rdata_q;

  // Lane writes and a registered read that returns the pre-write word
  always_ff @(posedge iClk) begin
    rdata_q <= mem_q[iAddr];
    for (int i = 0; i < 4; i++) begin
      if (iWe[i]) mem_q[iAddr][i*8 +: 8] <= iWdata[i*8 +: 8];
    end
  end

  assign oRdata = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - load/store responder: request FSM, lane enables, load assembly
module data_mem_resp
  import data_mem_resp_pkg::*;
(
  input  logic  iClk,
  input  logic  iRstN,
  input  tMemOp iMemOp,
  output logic  oMemRdy,
  output tRegOp oRegOp,
  output logic  oErr
);

  tLsState           state_q, state_d;
  logic [cAddrW-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              store_q, store_d;
  logic              split_q, split_d;
  logic [3:0]        hi_we_q, hi_we_d;
  logic [cXLEN-1:0]  hi_wdata_q, hi_wdata_d;
  logic [cXLEN-1:0]  lo_word_q, lo_word_d;
  logic              dv_q, dv_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [cXLEN-1:0]  wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic              accept, illegal, misaligned;
  logic [1:0]        req_off;
  logic [cAddrW-1:0] req_idx;
  logic [7:0]        lane_wide;
  logic [2*cXLEN-1:0] wdata_wide;
  logic [2*cXLEN-1:0] ld_window, ld_shifted;
  logic [cXLEN-1:0]  ld_word, ld_result;
  logic [cAddrW-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [cXLEN-1:0]  ram_wdata, ram_rdata;
  logic              unused_bits;

  assign oMemRdy = (state_q == IDLE);

  // Decode the incoming request: legality, alignment and the 8-byte lane window
  always_comb begin
    req_off    = iMemOp.addr[1:0];
    req_idx    = iMemOp.addr[cAddrW+1:2];
    accept     = (iMemOp.read | iMemOp.write) & oMemRdy;
    case (iMemOp.opType)
      cLsB, cLsH, cLsW, cLsBU, cLsHU: illegal = 1'b0;
      default:                        illegal = 1'b1;
    endcase
    if (iMemOp.read && iMemOp.write) illegal = 1'b1;
    if (iMemOp.write && iMemOp.opType[2]) illegal = 1'b1;
    misaligned = ((iMemOp.opType[1:0] == 2'b10) && (req_off != 2'b00)) ||
                 ((iMemOp.opType[1:0] == 2'b01) && (req_off == 2'b11));
    lane_wide  = {4'b0000, size_mask(iMemOp.opType[1:0])} << req_off;
    wdata_wide = {{cXLEN{1'b0}}, iMemOp.data} << {req_off, 3'b000};
  end

  // Align the fetched bytes to bit 0 and extend according to the load type
  always_comb begin
    ld_window  = split_q ? {ram_rdata, lo_word_q} : {{cXLEN{1'b0}}, ram_rdata};
    ld_shifted = ld_window >> {off_q, 3'b000};
    ld_word    = ld_shifted[cXLEN-1:0];
    case (op_q)
      cLsB:    ld_result = {{(cXLEN-8){ld_word[7]}}, ld_word[7:0]};
      cLsH:    ld_result = {{(cXLEN-16){ld_word[15]}}, ld_word[15:0]};
      cLsBU:   ld_result = {{(cXLEN-8){1'b0}}, ld_word[7:0]};
      cLsHU:   ld_result = {{(cXLEN-16){1'b0}}, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  // Next-state, RAM port drive and writeback/error generation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    off_d      = off_q;
    op_d       = op_q;
    rd_d       = rd_q;
    store_d    = store_q;
    split_d    = split_q;
    hi_we_d    = hi_we_q;
    hi_wdata_d = hi_wdata_q;
    lo_word_d  = lo_word_q;
    dv_d       = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    ram_addr   = idx_q;
    ram_we     = 4'b0000;
    ram_wdata  = hi_wdata_q;
    case (state_q)
      IDLE: begin
        ram_addr  = req_idx;
        ram_wdata = wdata_wide[cXLEN-1:0];
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            idx_d      = req_idx;
            off_d      = req_off;
            op_d       = iMemOp.opType;
            rd_d       = iMemOp.rdAddr;
            store_d    = iMemOp.write;
            split_d    = misaligned;
            hi_we_d    = lane_wide[7:4];
            hi_wdata_d = wdata_wide[2*cXLEN-1:cXLEN];
            ram_we     = iMemOp.write ? lane_wide[3:0] : 4'b0000;
            if (misaligned)       state_d = BEAT1;
            else if (iMemOp.read) state_d = RESP;
          end
        end
      end
      BEAT1: begin
        // word n+1 wraps naturally within the index width
        ram_addr  = idx_q + cAddrW'(1);
        ram_we    = store_q ? hi_we_q : 4'b0000;
        lo_word_d = ram_rdata;
        state_d   = store_q ? IDLE : RESP;
      end
      RESP: begin
        dv_d      = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = ld_result;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset aborts any access in flight
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      off_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      store_q    <= 1'b0;
      split_q    <= 1'b0;
      hi_we_q    <= '0;
      hi_wdata_q <= '0;
      lo_word_q  <= '0;
      dv_q       <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      store_q    <= store_d;
      split_q    <= split_d;
      hi_we_q    <= hi_we_d;
      hi_wdata_q <= hi_wdata_d;
      lo_word_q  <= lo_word_d;
      dv_q       <= dv_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  // Requests seen while reset is held must not reach the array
  data_mem_resp_byte_ram u_ram (
    .iClk   (iClk),
    .iAddr  (ram_addr),
    .iWe    (iRstN ? ram_we : 4'b0000),
    .iWdata (ram_wdata),
    .oRdata (ram_rdata)
  );

  assign oRegOp.dv   = dv_q;
  assign oRegOp.addr = wb_addr_q;
  assign oRegOp.data = wb_data_q;
  assign oErr        = err_q;

  assign unused_bits = ^{iMemOp.addr[cXLEN-1:cAddrW+2], ld_shifted[2*cXLEN-1:cXLEN]};

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - scoreboard bench for the data-memory responder
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  tMemOp mem_op;
  logic  mem_rdy;
  tRegOp reg_op;
  logic  err;

  data_mem_resp dut (
    .iClk    (clk),
    .iRstN   (rst_n),
    .iMemOp  (mem_op),
    .oMemRdy (mem_rdy),
    .oRegOp  (reg_op),
    .oErr    (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] due;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] err_q[$];
  logic [7:0]  model [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Writeback and error monitor, popping expectations from the scoreboard
  always @(negedge clk) begin
    wb_t         e;
    logic [31:0] due;
    if (rst_n === 1'b1) begin
      if (reg_op.dv === 1'b1) begin
        if (wb_q.size() == 0) check_eq("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = wb_q.pop_front();
          check_eq("wb_addr", {27'd0, reg_op.addr}, {27'd0, e.rd});
          check_eq("wb_data", reg_op.data, e.data);
          check_eq("wb_latency", cyc, e.due);
        end
      end
      if (err === 1'b1) begin
        if (err_q.size() == 0) check_eq("err_unexpected", 32'd1, 32'd0);
        else begin
          due = err_q.pop_front();
          check_eq("err_latency", cyc, due);
        end
      end
    end
  end

  // Drive one request from a negedge; kind 1 expects a writeback, kind 2 an error pulse
  task automatic issue(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] op, input logic [4:0] rd,
                       input int kind, input logic [31:0] exp);
    int waits = 0;
    int lat;
    lat = (((op[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
           ((op[1:0] == 2'b01) && (addr[1:0] == 2'b11))) ? 3 : 2;
    mem_op.read   = rd_en;
    mem_op.write  = wr_en;
    mem_op.addr   = addr;
    mem_op.data   = data;
    mem_op.opType = op;
    mem_op.rdAddr = rd;
    while (mem_rdy !== 1'b1 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (mem_rdy !== 1'b1) check_eq("rdy_timeout", 32'd0, 32'd1);
    if (kind == 1) wb_q.push_back('{rd, exp, cyc + lat});
    if (kind == 2) err_q.push_back(cyc + 1);
    @(negedge clk);
    mem_op.read  = 1'b0;
    mem_op.write = 1'b0;
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    issue(1'b0, 1'b1, addr, data, op, 5'd0, 0, 32'd0);
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] exp);
    issue(1'b1, 1'b0, addr, 32'd0, op, rd, 1, exp);
  endtask

  task automatic drain();
    int n = 0;
    while ((wb_q.size() != 0 || err_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", wb_q.size() + err_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] op, input int a);
    logic [31:0] w;
    int i;
    i = a - 256;
    w = {model[i+3], model[i+2], model[i+1], model[i]};
    case (op)
      3'b000:  exp_load = {{24{w[7]}}, w[7:0]};
      3'b001:  exp_load = {{16{w[15]}}, w[15:0]};
      3'b100:  exp_load = {24'd0, w[7:0]};
      3'b101:  exp_load = {16'd0, w[15:0]};
      default: exp_load = w;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] d;
    int          a, nb;
    mem_op = '0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy",  {31'd0, mem_rdy},   32'd1);
    check_eq("rst_dv",   {31'd0, reg_op.dv}, 32'd0);
    check_eq("rst_addr", {27'd0, reg_op.addr}, 32'd0);
    check_eq("rst_data", reg_op.data, 32'd0);
    check_eq("rst_err",  {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // aligned word store then load; stores stream, loads occupy two cycles
    store(cLsW, 32'h10, 32'hDEADBEEF);
    check_eq("sw_rdy_next", {31'd0, mem_rdy}, 32'd1);
    load(cLsW, 32'h10, 5'd5, 32'hDEADBEEF);
    check_eq("lw_rdy_busy", {31'd0, mem_rdy}, 32'd0);
    drain();

    // byte store with sign/zero extension
    store(cLsB, 32'h13, 32'h80);
    load(cLsB,  32'h13, 5'd1, 32'hFFFFFF80);
    load(cLsBU, 32'h13, 5'd2, 32'h00000080);
    load(cLsW,  32'h10, 5'd3, 32'h80ADBEEF);
    drain();

    // misaligned word store split across two words
    store(cLsW, 32'h20, 32'h0);
    store(cLsW, 32'h24, 32'h0);
    store(cLsW, 32'h22, 32'h11223344);
    check_eq("split_rdy_busy", {31'd0, mem_rdy}, 32'd0);
    @(negedge clk);
    check_eq("split_rdy_back", {31'd0, mem_rdy}, 32'd1);
    load(cLsW, 32'h20, 5'd4, 32'h33440000);
    load(cLsW, 32'h24, 5'd6, 32'h00001122);
    load(cLsW, 32'h22, 5'd7, 32'h11223344);
    load(cLsH, 32'h23, 5'd8, 32'h00002233);
    drain();

    // split halfword wrapping from the top word to word 0
    store(cLsB, (cRamDepth - 1) * 4 + 3, 32'hAB);
    store(cLsB, 32'h0, 32'h7F);
    load(cLsH,  (cRamDepth - 1) * 4 + 3, 5'd9, 32'h00007FAB);
    drain();

    // illegal requests: error pulse, no writeback, RAM untouched
    store(cLsW, 32'h30, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 32'h30, 32'h0,    3'b011, 5'd10, 2, 32'd0);
    issue(1'b0, 1'b1, 32'h30, 32'h1234, cLsHU,  5'd0,  2, 32'd0);
    issue(1'b1, 1'b1, 32'h30, 32'h0,    cLsW,   5'd11, 2, 32'd0);
    drain();
    load(cLsW, 32'h30, 5'd12, 32'hCAFEF00D);
    drain();

    // mixed random traffic against a byte model
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      store(cLsW, 32'h100 + i * 4, d);
      for (int k = 0; k < 4; k++) model[i*4+k] = d[k*8 +: 8];
    end
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 2));
      a  = 256 + $urandom_range(0, 59);
      d  = $urandom;
      store(op, a, d);
      nb = (op == cLsB) ? 1 : (op == cLsH) ? 2 : 4;
      for (int k = 0; k < nb; k++) model[a-256+k] = d[k*8 +: 8];
      case ($urandom_range(0, 4))
        0: op = cLsB;
        1: op = cLsH;
        2: op = cLsW;
        3: op = cLsBU;
        default: op = cLsHU;
      endcase
      a = 256 + $urandom_range(0, 59);
      load(op, a, 5'($urandom_range(0, 31)), exp_load(op, a));
    end
    drain();

    // reset during the second beat of a split store
    store(cLsW, 32'h40, 32'h0);
    store(cLsW, 32'h44, 32'h0);
    mem_op.read   = 1'b0;
    mem_op.write  = 1'b1;
    mem_op.addr   = 32'h42;
    mem_op.data   = 32'hAABBCCDD;
    mem_op.opType = cLsW;
    check_eq("mid_rst_rdy_pre", {31'd0, mem_rdy}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rdy",  {31'd0, mem_rdy},   32'd1);
    check_eq("mid_rst_dv",   {31'd0, reg_op.dv}, 32'd0);
    check_eq("mid_rst_data", reg_op.data, 32'd0);
    mem_op.write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(cLsW, 32'h40, 5'd13, 32'hCCDD0000);
    load(cLsW, 32'h44, 5'd14, 32'h00000000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
Data-memory responder for the load/store path: accepts a tMemOp request from the memory stage, performs the byte/half/word access on a byte-lane-enabled data RAM, and returns load results as a tRegOp writeback. It handles misaligned accesses by splitting them into two word beats with a small state machine. It back-pressures the requester with a ready signal while a multi-beat access is in flight.

Parameters:
cXLEN, 32, data/address width in bits
cRamDepth, 1024, data RAM depth in 32-bit words (power of two)
cAddrW, $clog2(cRamDepth), word-index width

Ports:
iClk  in  1  clock, all state on rising edge
iRstN  in  1  asynchronous, active-low reset
iMemOp  in  tMemOp  request: read, write, addr (byte address), data, opType[2:0] (RISC-V funct3), rdAddr[4:0]
oMemRdy  out  1  high when a new iMemOp is accepted this cycle
oRegOp  out  tRegOp  load writeback: dv, addr[4:0], data[cXLEN-1:0]
oErr  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (async, iRstN=0): state IDLE, oMemRdy=1, oRegOp.dv=0, oRegOp.addr=0, oRegOp.data=0, oErr=0. RAM contents are not cleared.
- Acceptance: a request is taken when (iMemOp.read|iMemOp.write) && oMemRdy. While oMemRdy=0, iMemOp is ignored and the requester holds it.
- Word index: addr[cAddrW+1:2]; byte offset: addr[1:0]. Index wraps modulo cRamDepth, including word n+1 of a split access at the top word.
- Legal opType values:
  - 000 B / 001 H / 010 W for loads and stores.
  - 100 BU / 101 HU for loads only.
- Illegal requests pulse oErr 1 cycle after acceptance, perform no RAM access and give no writeback:
  - any other opType;
  - a store with 100 or 101;
  - read and write both set.
- Misaligned access: W with offset!=0, or H with offset==3. It needs two beats: lanes at offset..3 in word n, the remainder in word n+1.
- States:
  - IDLE: on an aligned request, drive RAM beat 0 and go to RESP if it is a load; an aligned store stays in IDLE. On a misaligned request, drive beat 0 and go to BEAT1.
  - BEAT1: drive word n+1, then go to RESP for a load or IDLE for a store. oMemRdy=0.
  - RESP: assemble the load and go to IDLE. oMemRdy=0.
- Stores: per-lane byte enables; lanes taken from iMemOp.data shifted left by offset*8. Unselected bytes are unchanged. No read-modify-write.
- Loads:
  - Gather bytes from the beat(s) and shift right by offset*8.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Latch rdAddr at acceptance.
- Latency, counted from the acceptance edge:
  - aligned load: oRegOp.dv=1 for 1 cycle, 2 cycles after acceptance;
  - misaligned load: 3 cycles;
  - aligned store: 1 cycle occupancy;
  - misaligned store: 2 cycles.
- Throughput: aligned stores back-to-back every cycle; aligned loads 1 per 2 cycles.
- rdAddr=0: the writeback is still issued with addr=0; the register file discards it.
- oRegOp.addr/data hold their last value when dv=0.
- Reset mid-operation: the FSM aborts to IDLE immediately and a pending writeback is dropped. A store beat already clocked into RAM stays; the second beat is not written.
- RAM read-during-write on the same word returns old data. This cannot occur inside one request.

Decomposition:
- corePckg additions:
  - tMemOp/tRegOp (existing);
  - localparams for the funct3 encodings cLsB, cLsH, cLsW, cLsBU, cLsHU;
  - enum tLsState {IDLE, BEAT1, RESP}.
- Sub-module byte_ram: single-port, cRamDepth x cXLEN, 4 byte write enables, 1-cycle registered read, no reset on the array.
- Top module: FSM, lane/enable generation, load assembly and extension.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 rdAddr=5 -> oRegOp.dv=1 exactly 2 cycles after LW acceptance, addr=5, data=0xDEADBEEF.
- SB addr=0x13 data=0x80, then LB and LBU addr=0x13 -> LB returns 0xFFFFFF80; LBU returns 0x00000080. Word 0x10 reads 0x80ADBEEF.
- SW addr=0x22 data=0x11223344 (misaligned) -> oMemRdy=0 for 1 cycle; word 0x20 bytes[3:2]=0x44,0x33; word 0x24 bytes[1:0]=0x22,0x11. LW addr=0x22 returns 0x11223344 with dv 3 cycles after acceptance.
- LH addr=((cRamDepth-1)*4+3) after writing 0xAB to that byte and 0x7F to byte 0 of word 0 -> returns 0x00007FAB, showing wrap-around.
- Illegal requests: opType=011 read; SH with opType=101; read=write=1 -> each gives an oErr 1-cycle pulse, no dv, and RAM unchanged (checked by readback).
- Assert iRstN low during BEAT1 of a misaligned SW -> oMemRdy=1 and dv=0 immediately; word n is written, word n+1 is unchanged.
